// File: rtl/tpram_dual_port.sv
// True dual-port RAM, single clock domain.
// Two independent read/write ports (A and B) share one array of 2^aw words of
// dw bits. Each port registers its read address. Read data is driven
// combinationally from the array through that register, so a port sees a word
// written on the same edge one cycle later (write-through). When both ports
// write the same word on the same edge, port A's data is stored.
module tpram_dual_port #(
  parameter int aw = 11,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_a,
  input  logic          we_a,
  input  logic          oe_a,
  input  logic [aw-1:0] addr_a,
  input  logic [dw-1:0] di_a,
  output logic [dw-1:0] do_a,
  input  logic          ce_b,
  input  logic          we_b,
  input  logic          oe_b,
  input  logic [aw-1:0] addr_b,
  input  logic [dw-1:0] di_b,
  output logic [dw-1:0] do_b
);

  localparam int depth = 1 << aw;

  logic [dw-1:0] mem [depth];
  logic [aw-1:0] ra_a;
  logic [aw-1:0] ra_b;
  logic          wr_a;
  logic          wr_b;

  // Write strobes; writes are held off while rst is asserted and resume on the
  // first edge after it drops.
  assign wr_a = ce_a & we_a & ~rst;
  assign wr_b = ce_b & we_b & ~rst;

  // Array write. Port B is written first so that port A's assignment, being
  // the later non-blocking update, wins when both target the same word.
  // NOTE: the array has no reset branch; clearing 2^aw words on reset would
  // force it out of RAM macros into flops, and its contents are undefined
  // until written anyway.
  always_ff @(posedge clk) begin
    if (wr_b) mem[addr_b] <= di_b;
    if (wr_a) mem[addr_a] <= di_a;
  end

  // Registered read addresses; load while the port is enabled, hold otherwise.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_a <= '0;
      ra_b <= '0;
    end else begin
      if (ce_a) ra_a <= addr_a;
      if (ce_b) ra_b <= addr_b;
    end
  end

  // Read data straight from the array through the registered address; zero
  // when the output is disabled.
  assign do_a = oe_a ? mem[ra_a] : '0;
  assign do_b = oe_b ? mem[ra_b] : '0;

endmodule

// File: tb/tb_tpram_dual_port.sv
// Self-checking bench for tpram_dual_port (aw=11, dw=8).
// A behavioural model (plain array plus per-port latched address) predicts the
// read data; words never written are not compared.
module tb_tpram_dual_port;

  localparam int aw    = 11;
  localparam int dw    = 8;
  localparam int depth = 1 << aw;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce_a, we_a, oe_a;
  logic [aw-1:0] addr_a;
  logic [dw-1:0] di_a;
  logic [dw-1:0] do_a;
  logic          ce_b, we_b, oe_b;
  logic [aw-1:0] addr_b;
  logic [dw-1:0] di_b;
  logic [dw-1:0] do_b;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [dw-1:0] ref_mem   [depth];
  bit            ref_valid [depth];
  logic [aw-1:0] m_ra_a;
  logic [aw-1:0] m_ra_b;

  tpram_dual_port #(.aw(aw), .dw(dw)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce_a   (ce_a),
    .we_a   (we_a),
    .oe_a   (oe_a),
    .addr_a (addr_a),
    .di_a   (di_a),
    .do_a   (do_a),
    .ce_b   (ce_b),
    .we_b   (we_b),
    .oe_b   (oe_b),
    .addr_b (addr_b),
    .di_b   (di_b),
    .do_b   (do_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: apply the memory rules to the model at the rising edge (A wins
  // on a same-address collision), then return at the falling edge where
  // outputs are sampled and the next inputs are driven.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (ce_b && we_b) begin ref_mem[addr_b] = di_b; ref_valid[addr_b] = 1'b1; end
      if (ce_a && we_a) begin ref_mem[addr_a] = di_a; ref_valid[addr_a] = 1'b1; end
      if (ce_a) m_ra_a = addr_a;
      if (ce_b) m_ra_b = addr_b;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ce_a = 0; we_a = 0; addr_a = '0; di_a = '0;
    ce_b = 0; we_b = 0; addr_b = '0; di_b = '0;
  endtask

  task automatic write_a(input logic [aw-1:0] a, input logic [dw-1:0] d);
    ce_a = 1; we_a = 1; addr_a = a; di_a = d;
    tick();
    ce_a = 0; we_a = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    oe_a = 0; oe_b = 1;
    rst = 1;
    m_ra_a = '0; m_ra_b = '0;
    #12;
    checks++;
    if (do_a !== 8'h00) begin
      errors++; $display("FAIL reset_do_a_disabled: got %h expected 00", do_a);
    end
    @(negedge clk);
    rst = 0;
    // ra_b must be 0 after reset: write word 0 while port B is disabled.
    write_a(11'h000, 8'h3C);
    checks++;
    if (do_b !== 8'h3C) begin
      errors++; $display("FAIL reset_ra_b_zero: got %h expected 3c", do_b);
    end
  endtask

  task automatic test_write_read();
    logic [dw-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    oe_b = 1;
    for (int i = 0; i < 3; i++) write_a(aw'(i), vals[i]);
    ce_b = 1;
    for (int i = 0; i < 3; i++) begin
      addr_b = aw'(i);
      tick();
      checks++;
      if (do_b !== vals[i]) begin
        errors++; $display("FAIL write_read addr %0d: got %h expected %h", i, do_b, vals[i]);
      end
    end
    ce_b = 0;
  endtask

  task automatic test_write_through();
    write_a(11'h7FF, 8'hA5);
    ce_b = 1; addr_b = 11'h7FF; oe_b = 1;
    tick();
    checks++;
    if (do_b !== 8'hA5) begin
      errors++; $display("FAIL wt_old_value: got %h expected a5", do_b);
    end
    ce_a = 1; we_a = 1; addr_a = 11'h7FF; di_a = 8'h5A;
    #1;
    checks++;
    if (do_b !== 8'hA5) begin
      errors++; $display("FAIL wt_before_edge: got %h expected a5", do_b);
    end
    tick();
    ce_a = 0; we_a = 0;
    checks++;
    if (do_b !== 8'h5A) begin
      errors++; $display("FAIL wt_after_edge: got %h expected 5a", do_b);
    end
    ce_b = 0;
  endtask

  task automatic test_hold();
    write_a(11'd3, 8'hC3);
    write_a(11'd9, 8'h96);
    ce_b = 1; addr_b = 11'd3; oe_b = 1;
    tick();
    ce_b = 0; addr_b = 11'd9;
    tick();
    checks++;
    if (do_b !== ref_mem[3]) begin
      errors++; $display("FAIL hold_ce_b_low: got %h expected %h", do_b, ref_mem[3]);
    end
    oe_b = 0;
    #1;
    checks++;
    if (do_b !== 8'h00) begin
      errors++; $display("FAIL oe_b_low: got %h expected 00", do_b);
    end
    oe_b = 1;
  endtask

  task automatic test_collision();
    ce_a = 1; we_a = 1; addr_a = 11'h100; di_a = 8'hAA;
    ce_b = 1; we_b = 1; addr_b = 11'h100; di_b = 8'hBB;
    tick();
    we_a = 0; we_b = 0; ce_a = 0;
    tick();
    checks++;
    if (do_b !== 8'hAA) begin
      errors++; $display("FAIL collision_a_wins: got %h expected aa", do_b);
    end
    ce_a = 1; we_a = 1; addr_a = 11'h101; di_a = 8'h77;
    ce_b = 1; we_b = 1; addr_b = 11'h102; di_b = 8'h88;
    tick();
    we_a = 0; we_b = 0; oe_a = 1; oe_b = 1;
    tick();
    checks++;
    if (do_a !== 8'h77) begin
      errors++; $display("FAIL split_write_a: got %h expected 77", do_a);
    end
    checks++;
    if (do_b !== 8'h88) begin
      errors++; $display("FAIL split_write_b: got %h expected 88", do_b);
    end
    ce_a = 0; ce_b = 0;
  endtask

  task automatic test_mid_reset();
    logic [dw-1:0] exp0;
    for (int i = 0; i < 16; i++) write_a(aw'(i), dw'($urandom));
    oe_a = 1; oe_b = 1;
    ce_b = 1; addr_b = 11'd7;
    tick();
    ce_b = 0;
    checks++;
    if (do_b !== ref_mem[7]) begin
      errors++; $display("FAIL pre_reset_read: got %h expected %h", do_b, ref_mem[7]);
    end
    #2 rst = 1;
    m_ra_a = '0; m_ra_b = '0;
    exp0 = ref_mem[0];
    #1;
    checks++;
    if (do_b !== exp0) begin
      errors++; $display("FAIL async_reset_do_b: got %h expected %h", do_b, exp0);
    end
    checks++;
    if (do_a !== exp0) begin
      errors++; $display("FAIL async_reset_do_a: got %h expected %h", do_a, exp0);
    end
    tick();
    rst = 0;
    ce_b = 1; addr_b = 11'd5;
    tick();
    ce_b = 0;
    checks++;
    if (do_b !== ref_mem[5]) begin
      errors++; $display("FAIL post_reset_read5: got %h expected %h", do_b, ref_mem[5]);
    end
  endtask

  task automatic test_random();
    logic [dw-1:0] exp;
    for (int n = 0; n < 400; n++) begin
      ce_a = 1'($urandom); we_a = 1'($urandom); oe_a = 1'($urandom);
      ce_b = 1'($urandom); we_b = 1'($urandom); oe_b = 1'($urandom);
      addr_a = ($urandom_range(0, 7) == 0) ? aw'($urandom) : aw'($urandom_range(0, 31));
      addr_b = ($urandom_range(0, 7) == 0) ? aw'($urandom) : aw'($urandom_range(0, 31));
      di_a = dw'($urandom); di_b = dw'($urandom);
      tick();
      if (!oe_a || ref_valid[m_ra_a]) begin
        exp = oe_a ? ref_mem[m_ra_a] : '0;
        checks++;
        if (do_a !== exp) begin
          errors++; $display("FAIL random_a cycle %0d ra %h: got %h expected %h", n, m_ra_a, do_a, exp);
        end
      end
      if (!oe_b || ref_valid[m_ra_b]) begin
        exp = oe_b ? ref_mem[m_ra_b] : '0;
        checks++;
        if (do_b !== exp) begin
          errors++; $display("FAIL random_b cycle %0d ra %h: got %h expected %h", n, m_ra_b, do_b, exp);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < depth; i++) begin
      ref_mem[i] = '0;
      ref_valid[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_write_through();
    test_hold();
    test_collision();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpram_dual_port.md
Name: tpram_dual_port

Overview:
- Generic true dual-port RAM: two independent read/write ports (A and B) over one shared array of 2^aw words of dw bits.
- Used as the 2 KiB LZS decompressor history buffer, configured aw=11, dw=8.
- Port A writes decoded bytes; port B reads back-references.
- Both ports run on a single clock domain.

Parameters:
- aw, 11, address width; depth = 2^aw words.
- dw, 8, data word width.

Ports:
- clk  input  1  clock; all storage and address registers update on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- ce_a  input  1  port A chip enable.
- we_a  input  1  port A write enable; effective only when ce_a=1.
- oe_a  input  1  port A output enable.
- addr_a  input  aw  port A address.
- di_a  input  dw  port A write data.
- do_a  output  dw  port A read data.
- ce_b  input  1  port B chip enable.
- we_b  input  1  port B write enable; effective only when ce_b=1.
- oe_b  input  1  port B output enable.
- addr_b  input  aw  port B address.
- di_b  input  dw  port B write data.
- do_b  output  dw  port B read data.

Behaviour:
- Memory: array of 2^aw x dw. Contents are not cleared by rst and are undefined until written.
- Write: on rising clk, if ce_x=1 and we_x=1, then mem[addr_x] <= di_x. No write when ce_x=0.
- Read address: each port has a registered read address ra_x.
  - On rising clk, if ce_x=1, ra_x <= addr_x; if ce_x=0, ra_x holds.
  - rst asynchronously clears ra_a and ra_b to 0.
- Read data: do_x = mem[ra_x] when oe_x=1, else all zeros. This is driven combinationally from the array (no tristate).
- Read latency is 1 cycle: the address presented at edge N gives its data after edge N, valid until the next edge.
- Write-through: if the same address is written at edge N (either port) and latched into ra_x at edge N, do_x shows the newly written data after edge N.
  - Data read at an address before a write reflects the old contents until that write's edge.
- Simultaneous writes to the same address from A and B in one cycle: port A's data is stored.
  - Writes to different addresses both complete.
- Address wrap: addresses are aw bits; there is no out-of-range access.
- Reset mid-operation: ra_x immediately become 0, so do_x shows mem[0] (if oe_x=1). Memory contents are preserved. Writes resume on the first clk edge after rst deasserts.
- Write-enable interplay: a port with we_x=1 still updates ra_x (if ce_x=1), so do_x reflects the written word on the next cycle.

Test Plan:
- Reset: assert rst with oe_b=1 -> ra_b=0; do_b=mem[0]. With oe_a=0 -> do_a=0x00.
- Port A writes 0x11,0x22,0x33 at addresses 0,1,2. Port B then reads addresses 0,1,2 on consecutive cycles (ce_b=1, oe_b=1) -> do_b = 0x11,0x22,0x33, each one cycle after its address.
- Write-through: cycle N, port A writes 0x5A to 0x7FF while addr_b=0x7FF, ce_b=1 -> do_b=0x5A after edge N. A previous value 0xA5 at 0x7FF is visible before that edge.
- Hold with ce_b=0: latch addr_b=3, then drop ce_b and change addr_b=9 -> do_b still shows mem[3].
- Collision: A writes 0xAA and B writes 0xBB to address 0x100 in the same cycle -> a later read gives 0xAA. Separate addresses 0x101/0x102 written in one cycle both read back correctly.
- Mid-run reset: after filling addresses 0..15, pulse rst asynchronously -> ra_x=0 and do_b=mem[0]. Reading address 5 afterwards returns its pre-reset value.
